// File: rtl/fb_pkg.sv
// Framebuffer geometry, pixel type and address helper shared by the
// framebuffer arbiter and its requesters.
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 800;
  localparam int unsigned FB_HEIGHT = 480;
  localparam int          FB_ADDR_W = $clog2(FB_WIDTH * FB_HEIGHT);
  localparam int          FB_PIX_W  = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Linear pixel address of (x, y) in a row-major framebuffer.
  function automatic logic [FB_ADDR_W-1:0] pix_addr(input int unsigned x,
                                                    input int unsigned y);
    int unsigned lin;
    lin = y * FB_WIDTH + x;
    return lin[FB_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/fb_rd_pipe.sv
// Read-tag pipeline: a bare valid shift register, RD_LAT stages deep,
// whose last stage marks the cycle in which RAM read data is captured.
module fb_rd_pipe
  import fb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic vga_clk,
  input  logic reset_n,
  input  logic i_vld,
  output logic o_cap
);

  logic [RD_LAT-1:0] r_vld_p;

  // Shift the grant tag along; reset drops every in-flight read.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= i_vld;
      for (int k = 1; k < RD_LAT; k++) begin
        r_vld_p[k] <= r_vld_p[k-1];
      end
    end
  end

  assign o_cap = r_vld_p[RD_LAT-1];

endmodule

// File: rtl/fb_mem_arbiter.sv
// Single-port framebuffer RAM arbiter: display reads have priority, the
// pixel writer is guaranteed a slot after MAX_STARVE lost arbitrations.
// Read data returns a fixed 1+RD_LAT cycles after the grant.
module fb_mem_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int PIX_W      = FB_PIX_W,
  parameter int RD_LAT     = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_data_valid,
  output logic [PIX_W-1:0]  rd_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [2:0]        starve_cnt
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_STARVE);

  logic w_wr_force;
  logic w_wr_xfer;
  logic w_cap_p;

  // Arbitration is purely combinational so the requesters see the grant
  // in the same cycle; reset gates both handshakes.
  assign w_wr_force = (starve_cnt == MAX_CNT);
  assign rd_gnt     = reset_n && rd_req && !(w_wr_force && wr_valid);
  assign wr_ready   = reset_n && !rd_gnt;
  assign w_wr_xfer  = wr_valid && wr_ready;

  fb_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .i_vld   (rd_gnt),
    .o_cap   (w_cap_p)
  );

  // Register the RAM command; address and write data hold when idle.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (rd_gnt) begin
      mem_en    <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= rd_addr;
    end else if (w_wr_xfer) begin
      mem_en    <= 1'b1;
      mem_we    <= 1'b1;
      mem_addr  <= wr_addr;
      mem_wdata <= wr_data;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // Count consecutive lost write arbitrations, saturating at the force level.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (w_wr_xfer) begin
      starve_cnt <= '0;
    end else if (wr_valid && (starve_cnt != MAX_CNT)) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  // Capture returning read data when the grant tag leaves the pipeline.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
    end else begin
      rd_data_valid <= w_cap_p;
      if (w_cap_p) begin
        rd_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: a reference arbiter/RAM model predicts grants,
// memory commands and read returns; expected read data is queued at grant
// time and compared when rd_data_valid fires. A second instance with
// RD_LAT=3 covers reset while reads are in flight.
module tb_fb_mem_arbiter;
  import fb_pkg::*;

  localparam int AW     = FB_ADDR_W;
  localparam int PW     = FB_PIX_W;
  localparam int MAX_ST = 4;

  typedef struct {
    logic [PW-1:0] d;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1 (RD_LAT=1)
  logic          reset_n, rd_req, rd_gnt, rd_data_valid, wr_valid, wr_ready;
  logic          mem_en, mem_we;
  logic [AW-1:0] rd_addr, wr_addr, mem_addr;
  logic [PW-1:0] rd_data, wr_data, mem_wdata, mem_rdata;
  logic [2:0]    starve_cnt;

  // Instance 2 (RD_LAT=3)
  logic          reset3_n, rd_req3, rd_gnt3, rd_data_valid3, wr_valid3, wr_ready3;
  logic          mem_en3, mem_we3;
  logic [AW-1:0] rd_addr3, wr_addr3, mem_addr3;
  logic [PW-1:0] rd_data3, wr_data3, mem_wdata3, mem_rdata3;
  logic [2:0]    starve_cnt3;

  fb_mem_arbiter #(.RD_LAT(1), .MAX_STARVE(MAX_ST)) u_dut (
    .vga_clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .starve_cnt(starve_cnt)
  );

  fb_mem_arbiter #(.RD_LAT(3), .MAX_STARVE(MAX_ST)) u_dut3 (
    .vga_clk(clk), .reset_n(reset3_n), .rd_req(rd_req3), .rd_addr(rd_addr3),
    .rd_gnt(rd_gnt3), .rd_data_valid(rd_data_valid3), .rd_data(rd_data3),
    .wr_valid(wr_valid3), .wr_addr(wr_addr3), .wr_data(wr_data3),
    .wr_ready(wr_ready3), .mem_en(mem_en3), .mem_we(mem_we3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .starve_cnt(starve_cnt3)
  );

  // Initial RAM contents derived from the address.
  function automatic logic [PW-1:0] pat(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'h5A, 8'hC3, a[7:0]};
  endfunction

  // RAM behind instance 1: combinational read of the registered address
  // gives data one cycle after the grant; writes land at the clock edge.
  logic [PW-1:0] ram [1024];
  logic          ram_init = 1'b1;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= pat(AW'(i));
    end else if (mem_en && mem_we) begin
      ram[mem_addr[9:0]] <= mem_wdata;
    end
  end
  assign mem_rdata  = ram[mem_addr[9:0]];
  assign mem_rdata3 = {8'h3C, mem_addr3[15:0]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Reference model state for instance 1
  logic [PW-1:0] ref_mem [1024];
  exp_t          exp_q[$];
  int            m_starve;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [PW-1:0] m_wdata;
  logic          mon_on = 1'b0;

  // Read-return scoreboard: a valid must appear exactly when due, no other time.
  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("rd_valid", 32'(rd_data_valid), 32'd1);
        chk("rd_data", 32'(rd_data), 32'(exp_q[0].d));
        void'(exp_q.pop_front());
      end else begin
        chk("rd_valid_idle", 32'(rd_data_valid), 32'd0);
      end
    end
  end

  // One clock of instance 1: check handshakes and the registered command
  // against the model, then advance the model across the clock edge.
  task automatic cycle(output logic granted);
    logic g_rd, g_wr;
    int   n;
    exp_t e;
    g_rd = reset_n && rd_req && !((m_starve == MAX_ST) && wr_valid);
    g_wr = reset_n && !g_rd;
    @(negedge clk);
    n = cyc;
    chk("rd_gnt", 32'(rd_gnt), 32'(g_rd));
    chk("wr_ready", 32'(wr_ready), 32'(g_wr));
    chk("starve_cnt", 32'(starve_cnt), 32'(m_starve));
    chk("mem_en", 32'(mem_en), 32'(m_en));
    chk("mem_we", 32'(mem_we), 32'(m_we));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    @(posedge clk);
    if (!reset_n) begin
      m_starve = 0; m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      exp_q.delete();
    end else begin
      if (g_rd) begin
        e.d = ref_mem[rd_addr[9:0]];
        e.due = n + 2;
        exp_q.push_back(e);
        m_en = 1'b1; m_we = 1'b0; m_addr = rd_addr;
      end else if (wr_valid) begin
        ref_mem[wr_addr[9:0]] = wr_data;
        m_en = 1'b1; m_we = 1'b1; m_addr = wr_addr; m_wdata = wr_data;
      end else begin
        m_en = 1'b0; m_we = 1'b0;
      end
      if (wr_valid && g_wr) m_starve = 0;
      else if (wr_valid && m_starve < MAX_ST) m_starve++;
    end
    granted = g_rd;
    #1;
  endtask

  task automatic idle(input int n);
    logic g;
    rd_req = 1'b0; wr_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(g);
  endtask

  task automatic step3();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic  g;
    rgb_t  red;
    int    rd_i, wr_i;
    red = '{r: 8'hFF, g: 8'h00, b: 8'h00};

    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(AW'(i));
    m_starve = 0; m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;

    reset_n  = 1'b0; rd_req  = 1'b1; rd_addr  = '0; wr_valid  = 1'b1;
    wr_addr  = '0;   wr_data = '0;
    reset3_n = 1'b0; rd_req3 = 1'b0; rd_addr3 = '0; wr_valid3 = 1'b0;
    wr_addr3 = '0;   wr_data3 = '0;

    @(posedge clk);
    #1;
    ram_init = 1'b0;
    mon_on   = 1'b1;

    // Reset state: handshakes gated, registers cleared.
    cycle(g);
    cycle(g);
    reset_n = 1'b1;
    idle(2);

    // Reads only: consecutive addresses, one grant per cycle.
    for (int i = 0; i < 10; i++) begin
      rd_req = 1'b1; rd_addr = pix_addr(i, 0);
      cycle(g);
    end
    idle(4);
    chk("q_empty_reads", 32'(exp_q.size()), 32'd0);

    // Writes only, then read them back.
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(100 + i); wr_data = red;
      cycle(g);
    end
    idle(1);
    for (int i = 0; i < 8; i++) begin
      rd_req = 1'b1; rd_addr = AW'(100 + i);
      cycle(g);
    end
    idle(4);
    chk("q_empty_wrback", 32'(exp_q.size()), 32'd0);

    // Contention: both sides busy; display holds its address until granted.
    rd_i = 0; wr_i = 0;
    for (int i = 0; i < 17; i++) begin
      rd_req = 1'b1; rd_addr = AW'(300 + rd_i);
      wr_valid = 1'b1; wr_addr = AW'(300 + wr_i); wr_data = PW'(24'h00A000 + wr_i);
      cycle(g);
      if (g) rd_i++;
      else wr_i++;
    end
    chk("contention_reads", 32'(rd_i), 32'd14);
    chk("contention_writes", 32'(wr_i), 32'd3);
    idle(4);
    chk("q_empty_contend", 32'(exp_q.size()), 32'd0);

    // Idle hold: bring starve count to 2, then go quiet.
    wr_valid = 1'b1; wr_addr = AW'(500); wr_data = PW'(24'h123456);
    cycle(g);
    for (int i = 0; i < 2; i++) begin
      rd_req = 1'b1; rd_addr = AW'(500);
      wr_valid = 1'b1; wr_addr = AW'(501); wr_data = PW'(24'h654321);
      cycle(g);
    end
    idle(5);
    chk("idle_starve_hold", 32'(starve_cnt), 32'd2);
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    chk("q_empty_idle", 32'(exp_q.size()), 32'd0);

    // RD_LAT=3 instance: one read returns exactly four cycles after grant.
    reset3_n = 1'b1;
    rd_req3 = 1'b1; rd_addr3 = AW'(5);
    step3();
    rd_req3 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("lat3_valid", 32'(rd_data_valid3), (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) chk("lat3_data", 32'(rd_data3), 32'h3C0005);
      step3();
    end

    // Three reads in flight (writer starving), then a one-cycle reset.
    wr_valid3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_req3 = 1'b1; rd_addr3 = AW'(10 + i);
      step3();
    end
    reset3_n = 1'b0; rd_req3 = 1'b1;
    @(negedge clk);
    chk("rst_rd_gnt", 32'(rd_gnt3), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready3), 32'd0);
    chk("pre_rst_starve", 32'(starve_cnt3), 32'd3);
    step3();
    reset3_n = 1'b1; rd_req3 = 1'b0; wr_valid3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_no_valid", 32'(rd_data_valid3), 32'd0);
      if (k == 0) begin
        chk("rst_mem_en", 32'(mem_en3), 32'd0);
        chk("rst_mem_we", 32'(mem_we3), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata3), 32'd0);
        chk("rst_starve", 32'(starve_cnt3), 32'd0);
      end
      step3();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
Shares one single-port framebuffer RAM (WIDTH×HEIGHT RGB888 pixels) between two requesters:
- the display scan-out prefetcher (read side, feeds the per-pixel colour path);
- the pixel writer (camera/CPU side).

Reads have fixed priority. A starvation counter guarantees the writer a slot. Read data returns with a fixed, known latency.

Parameters:
WIDTH, 800, active pixels per line
HEIGHT, 480, active lines per frame
ADDR_W, $clog2(WIDTH*HEIGHT) = 19, pixel address width
PIX_W, 24, pixel width ({red, green, blue}, 8 bits each)
RD_LAT, 1, RAM read latency in cycles from registered mem_en (1..4)
MAX_STARVE, 4, consecutive lost write arbitrations before the writer wins

Ports:
vga_clk  in  1  single clock
reset_n  in  1  synchronous, active-low reset, sampled on posedge vga_clk
rd_req  in  1  display requests a read this cycle
rd_addr  in  ADDR_W  read pixel address
rd_gnt  out  1  combinational; read accepted this cycle
rd_data_valid  out  1  rd_data valid
rd_data  out  PIX_W  returned pixel
wr_valid  in  1  writer has a pixel
wr_addr  in  ADDR_W  write address
wr_data  in  PIX_W  write pixel
wr_ready  out  1  combinational; write accepted when wr_valid && wr_ready
mem_en  out  1  registered RAM enable
mem_we  out  1  registered RAM write enable
mem_addr  out  ADDR_W  registered RAM address
mem_wdata  out  PIX_W  registered RAM write data
mem_rdata  in  PIX_W  RAM read data, valid RD_LAT cycles after mem_en && !mem_we
starve_cnt  out  3  current starvation count (debug)

Behaviour:
Arbitration is evaluated every cycle N and is combinational on the inputs and starve_cnt.
- wr_force = (starve_cnt == MAX_STARVE).
- rd_gnt = rd_req && !(wr_force && wr_valid).
- wr_ready = !rd_gnt and not in reset. The writer sees ready whenever the read side is not granted, including when idle.
- A read and a write are never granted in the same cycle.

Starvation counter:
- Increments on each cycle with wr_valid && !wr_ready.
- Saturates at MAX_STARVE.
- Clears to 0 on a cycle with wr_valid && wr_ready.
- Holds when wr_valid = 0.

Memory command (cycle N+1, registered):
- Read grant: mem_en=1, mem_we=0, mem_addr=rd_addr.
- Write transfer: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
- Otherwise: mem_en=0, mem_we=0. mem_addr and mem_wdata hold their last values.

Read return:
- rd_data_valid asserts at cycle N+1+RD_LAT for each read granted at N.
- rd_data is registered from mem_rdata on that cycle; its latency is fixed at 1+RD_LAT.
- Back-to-back grants produce back-to-back valids, in order.
- The read tag pipeline is RD_LAT stages deep and carries no address.

Address range:
- Addresses ≥ WIDTH*HEIGHT are passed through unchanged. The requesters own range checking.

Reset (reset_n=0 at a posedge):
- mem_en, mem_we, rd_data_valid, starve_cnt, rd_data, mem_addr and mem_wdata clear to 0.
- Every read-pipeline stage clears, so in-flight reads are dropped and produce no valid after reset.
- While reset_n=0, rd_gnt=0 and wr_ready=0.

Simultaneous rd_req && wr_valid:
- With starve_cnt < MAX_STARVE, the read wins.
- With starve_cnt = MAX_STARVE, the write wins. The display must hold rd_req/rd_addr until rd_gnt.

Decomposition:
- Shared package fb_pkg holds:
  - WIDTH and HEIGHT defaults, ADDR_W derivation, PIX_W;
  - an RGB pixel packed type {r, g, b} of 8 bits each;
  - helper function pix_addr(x, y) = y*WIDTH + x.
- One sub-module, fb_rd_pipe: RD_LAT-deep valid shift register with synchronous clear, producing the rd_data capture enable.

Test Plan:
1. Reads only: rd_req=1, rd_addr=0..9 on consecutive cycles, RD_LAT=1 -> rd_gnt=1 every cycle; rd_data_valid from cycle 2 for 10 cycles; rd_data = RAM model contents in order.
2. Writes only: wr_valid=1 for 8 cycles, addresses 100..107, data 0xFF0000 -> wr_ready=1 throughout; mem_we=1 on cycles 1..8; starve_cnt stays 0; read-back of 100..107 returns 0xFF0000.
3. Contention: rd_req=1 and wr_valid=1 held, MAX_STARVE=4 -> reads granted 4 cycles, write granted on the 5th, pattern repeats 4:1; starve_cnt sequence 1,2,3,4,0.
4. Write preempts read: at the forced write slot, check rd_gnt=0, rd_addr held, then rd_gnt=1 next cycle. The display sees one extra cycle of latency and no lost or duplicated rd_data_valid.
5. Reset mid-operation: 3 reads in flight with RD_LAT=3, reset_n=0 for one cycle -> no rd_data_valid afterwards; starve_cnt=0; mem_en=0 the cycle after reset.
6. Idle hold: starve_cnt=2, wr_valid drops for 5 cycles with no requests -> starve_cnt stays 2, mem_en=0.
